cpu_mem_access_unit: RTL and testbench
======================================

// Module: cpu_mem_access_unit
// PURPOSE
//  Load/store engine between the multicycle CPU datapath (MEM_ACC/FETCH states) and the system memory bus.
//  Turns one core access (addr, wdata, funct3) into one bus transaction with byte enables.
//  Waits for the bus acknowledge, then returns aligned, sign/zero-extended load data.
//  Holds busy=1 while the core FSM must stall; flags misaligned and timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles waiting for bus_ack before abort; 0 = wait forever
//  ADDR_W       32   bus/core address width (data width fixed at 32)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  acc_req       in   1       core access request; sampled only in IDLE
//  acc_we        in   1       1 = store, 0 = load (instruction fetch = load, funct3=010)
//  acc_funct3    in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
//  acc_addr      in   ADDR_W  byte address
//  acc_wdata     in   32      store data, LSB-justified
//  acc_rdata     out  32      load result, aligned and extended; valid while acc_done=1
//  acc_done      out  1       1-cycle pulse: access finished (ok or error)
//  acc_busy      out  1       access in progress; core holds its state while 1
//  acc_misalign  out  1       with acc_done: address not aligned to size, no bus cycle issued
//  acc_bus_err   out  1       with acc_done: timeout expired
//  bus_req       out  1       bus request, held until bus_ack or abort
//  bus_we        out  1       bus write strobe
//  bus_addr      out  ADDR_W  word-aligned address (acc_addr[1:0] forced 00)
//  bus_be        out  4       byte enables
//  bus_wdata     out  32      store data replicated onto the selected lanes
//  bus_ack       in   1       bus completes transfer this cycle
//  bus_rdata     in   32      read word; valid when bus_ack=1
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (acc_rdata, bus_addr, bus_wdata, bus_be = 0).
//  FSM: IDLE, BUS, DONE, ERR.
//   IDLE: on acc_req, register addr/size/we/wdata.
//     Misaligned (H with addr[0]=1; W with addr[1:0]!=0): go to ERR.
//     Otherwise go to BUS. Reserved funct3 (011,110,111) is treated as W.
//   BUS: bus_req=1; bus_* outputs stable until ack. On bus_ack, capture bus_rdata -> DONE.
//     Timeout counter starts at 0 on entry and increments per cycle without ack.
//     TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 with no ack: -> ERR with bus_err, bus_req dropped next cycle.
//     Ack wins over timeout in the same cycle.
//   DONE: acc_done=1, acc_rdata valid for one cycle -> IDLE.
//   ERR: acc_done=1 plus acc_misalign or acc_bus_err; acc_rdata=0 -> IDLE.
//  acc_busy = (state != IDLE). acc_req while busy is ignored; no queueing.
//  Latency: issue cycle + 1; bus_ack N cycles after bus_req rises -> acc_done N+1 cycles after that.
//    Zero-wait ack gives acc_done 2 cycles after acc_req.
//  Byte enables: B 0001<<addr[1:0]; H 0011<<{addr[1],1'b0}; W 1111.
//  Write data: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
//  Load extraction: B/BU byte at lane addr[1:0]; H/HU half at addr[1].
//    B/H sign-extend bit 7/15; BU/HU zero-extend.
//  Reset mid-access: async return to IDLE; bus_req drops immediately; no acc_done generated.
// STRUCTURE
//  pkg_cpu_typedefs gains:
//    mem_acc_state_t {IDLE,BUS,DONE,ERR}
//    mem_size_t {MEM_B=3'b000,MEM_H=3'b001,MEM_W=3'b010,MEM_BU=3'b100,MEM_HU=3'b101}
//  Sub-module cpu_load_aligner (combinational): (rdata_word, addr[1:0], funct3) -> extended 32-bit result.
//  Top holds FSM, request registers, timeout counter, be/wdata generation.
// TESTING
//  LW addr 0x100, bus_ack 0 wait, bus_rdata 0xDEADBEEF -> bus_be 1111, acc_rdata 0xDEADBEEF, done 2 cyc after req.
//  LB addr 0x103, rdata 0x80xxxxxx -> be 1000, acc_rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x202, wdata 0x1234ABCD -> bus_we 1, be 1100, bus_wdata 0xABCDABCD, bus_addr 0x200.
//  LW addr 0x101 -> no bus_req, acc_done+acc_misalign next cycle, acc_rdata 0.
//  TIMEOUT_CYC=4, no ack -> bus_req high exactly 4 cycles, then acc_done+acc_bus_err.
//  rst_n low during BUS with 3 wait states -> bus_req 0 at once; new LW after reset completes normally.

Source files
------------

// File: rtl/cpu_mem_access_unit_pkg.sv
// Shared types for the CPU load/store engine.
//   mem_acc_state_t : engine FSM states
//   mem_size_t      : access size / extension encoding (funct3)
//   norm_size()     : maps a raw funct3 onto a legal size (reserved codes -> word)
package cpu_mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } mem_acc_state_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  // Reserved encodings (011, 110, 111) behave as a full word access.
  function automatic mem_size_t norm_size(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return MEM_B;
      3'b001:  return MEM_H;
      3'b100:  return MEM_BU;
      3'b101:  return MEM_HU;
      default: return MEM_W;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mem_access_unit_load_aligner.sv
// Combinational load aligner: picks the addressed byte/half out of a bus word
// and sign- or zero-extends it to 32 bits.
//   rdata_i   : raw 32-bit bus read word
//   addr_lo_i : byte offset within the word
//   size_i    : access size / extension
//   data_o    : aligned, extended load result
module cpu_load_aligner
  import cpu_mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  mem_size_t   size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for byte and halfword loads.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr_lo_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  // Extension according to access size.
  always_comb begin
    data_o = 32'h0000_0000;
    case (size_i)
      MEM_B:   data_o = {{24{byte_s[7]}}, byte_s};
      MEM_BU:  data_o = {24'h00_0000, byte_s};
      MEM_H:   data_o = {{16{half_s[15]}}, half_s};
      MEM_HU:  data_o = {16'h0000, half_s};
      MEM_W:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/cpu_mem_access_unit.sv
// Load/store engine between the multicycle CPU datapath and the memory bus.
// One core access becomes one bus transaction with byte enables; the load
// result comes back aligned and extended with a one-cycle done pulse.
//   clk_i, rst_ni      : clock (rising edge), async active-low reset
//   acc_*_i            : core request (sampled only while idle)
//   acc_rdata_o        : load result, valid with acc_done_o
//   acc_done_o         : one-cycle completion pulse (ok or error)
//   acc_busy_o         : core must stall while high
//   acc_misalign_o     : with done, misaligned address, no bus cycle issued
//   acc_bus_err_o      : with done, bus acknowledge timed out
//   bus_*_o / bus_*_i  : memory bus request side / response side
module cpu_mem_access_unit
  import cpu_mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              acc_req_i,
  input  logic              acc_we_i,
  input  logic [2:0]        acc_funct3_i,
  input  logic [ADDR_W-1:0] acc_addr_i,
  input  logic [31:0]       acc_wdata_i,
  output logic [31:0]       acc_rdata_o,
  output logic              acc_done_o,
  output logic              acc_busy_o,
  output logic              acc_misalign_o,
  output logic              acc_bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_acc_state_t    state_q;
  mem_size_t         size_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       acc_rdata_q;
  logic              acc_done_q, acc_busy_q, acc_misalign_q, acc_bus_err_q;
  logic              bus_req_q, bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q;

  mem_size_t   size_d;
  logic        misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data_s;

  // Decode the incoming request: size, alignment, lane enables, replicated data.
  always_comb begin
    size_d     = norm_size(acc_funct3_i);
    misalign_d = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = acc_wdata_i;
    case (size_d)
      MEM_B, MEM_BU: begin
        be_d    = 4'b0001 << acc_addr_i[1:0];
        wdata_d = {4{acc_wdata_i[7:0]}};
      end
      MEM_H, MEM_HU: begin
        misalign_d = acc_addr_i[0];
        be_d       = 4'b0011 << {acc_addr_i[1], 1'b0};
        wdata_d    = {2{acc_wdata_i[15:0]}};
      end
      MEM_W: begin
        misalign_d = (acc_addr_i[1:0] != 2'b00);
      end
      default: begin
        misalign_d = (acc_addr_i[1:0] != 2'b00);
      end
    endcase
  end

  cpu_load_aligner u_aligner (
    .rdata_i   (bus_rdata_i),
    .addr_lo_i (addr_lo_q),
    .size_i    (size_q),
    .data_o    (load_data_s)
  );

  // Access FSM with registered outputs and bus-wait timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      size_q         <= MEM_W;
      addr_lo_q      <= 2'b00;
      cnt_q          <= '0;
      acc_rdata_q    <= 32'h0000_0000;
      acc_done_q     <= 1'b0;
      acc_busy_q     <= 1'b0;
      acc_misalign_q <= 1'b0;
      acc_bus_err_q  <= 1'b0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_be_q       <= 4'b0000;
      bus_wdata_q    <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_req_i) begin
            size_q     <= size_d;
            addr_lo_q  <= acc_addr_i[1:0];
            acc_busy_q <= 1'b1;
            if (misalign_d) begin
              state_q        <= ERR;
              acc_done_q     <= 1'b1;
              acc_misalign_q <= 1'b1;
            end else begin
              state_q     <= BUS;
              cnt_q       <= '0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= acc_we_i;
              bus_addr_q  <= {acc_addr_i[ADDR_W-1:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        BUS: begin
          // Acknowledge takes priority over an expiring timeout.
          if (bus_ack_i) begin
            state_q     <= DONE;
            bus_req_q   <= 1'b0;
            acc_done_q  <= 1'b1;
            acc_rdata_q <= load_data_s;
          end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
            state_q       <= ERR;
            bus_req_q     <= 1'b0;
            acc_done_q    <= 1'b1;
            acc_bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          acc_done_q  <= 1'b0;
          acc_busy_q  <= 1'b0;
          acc_rdata_q <= 32'h0000_0000;
        end
        ERR: begin
          state_q        <= IDLE;
          acc_done_q     <= 1'b0;
          acc_busy_q     <= 1'b0;
          acc_misalign_q <= 1'b0;
          acc_bus_err_q  <= 1'b0;
        end
        default: begin
          state_q        <= IDLE;
          acc_done_q     <= 1'b0;
          acc_busy_q     <= 1'b0;
          acc_misalign_q <= 1'b0;
          acc_bus_err_q  <= 1'b0;
          bus_req_q      <= 1'b0;
        end
      endcase
    end
  end

  assign acc_rdata_o    = acc_rdata_q;
  assign acc_done_o     = acc_done_q;
  assign acc_busy_o     = acc_busy_q;
  assign acc_misalign_o = acc_misalign_q;
  assign acc_bus_err_o  = acc_bus_err_q;
  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_we_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_be_o       = bus_be_q;
  assign bus_wdata_o    = bus_wdata_q;

endmodule

// File: tb/tb_cpu_mem_access_unit.sv
module tb_cpu_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        acc_req_i, acc_we_i;
  logic [2:0]  acc_funct3_i;
  logic [31:0] acc_addr_i, acc_wdata_i;
  logic [31:0] acc_rdata_o;
  logic        acc_done_o, acc_busy_o, acc_misalign_o, acc_bus_err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  cpu_mem_access_unit #(.TIMEOUT_CYC(4), .ADDR_W(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .acc_req_i      (acc_req_i),
    .acc_we_i       (acc_we_i),
    .acc_funct3_i   (acc_funct3_i),
    .acc_addr_i     (acc_addr_i),
    .acc_wdata_i    (acc_wdata_i),
    .acc_rdata_o    (acc_rdata_o),
    .acc_done_o     (acc_done_o),
    .acc_busy_o     (acc_busy_o),
    .acc_misalign_o (acc_misalign_o),
    .acc_bus_err_o  (acc_bus_err_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_be_o       (bus_be_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_ack_i      (bus_ack_i),
    .bus_rdata_i    (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    acc_req_i    = 1'b1;
    acc_we_i     = we;
    acc_funct3_i = f3;
    acc_addr_i   = addr;
    acc_wdata_i  = wdata;
    tick();
    acc_req_i = 1'b0;
  endtask

  // Zero-wait acknowledge with given read word, then check the done cycle.
  task automatic ack_and_check(input string tag, input logic [31:0] rword,
                               input logic [31:0] exp_rdata);
    bus_ack_i   = 1'b1;
    bus_rdata_i = rword;
    tick();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    chk({tag, "_done"}, {31'b0, acc_done_o}, 32'd1);
    chk({tag, "_rdata"}, acc_rdata_o, exp_rdata);
    chk({tag, "_req_drop"}, {31'b0, bus_req_o}, 32'd0);
    tick();
    chk({tag, "_idle"}, {30'b0, acc_done_o, acc_busy_o}, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    acc_req_i = 1'b0; acc_we_i = 1'b0; acc_funct3_i = 3'b000;
    acc_addr_i = 32'h0; acc_wdata_i = 32'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    tick(); tick();
    chk("rst_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_flags", {28'b0, acc_done_o, acc_busy_o, acc_misalign_o, acc_bus_err_o}, 32'd0);
    chk("rst_rdata", acc_rdata_o, 32'h0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_be", {28'b0, bus_be_o}, 32'h0);
    chk("rst_wdata", bus_wdata_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // LW 0x100, zero wait: done two cycles after request
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    chk("lw_req", {31'b0, bus_req_o}, 32'd1);
    chk("lw_busy", {31'b0, acc_busy_o}, 32'd1);
    chk("lw_be", {28'b0, bus_be_o}, 32'hF);
    chk("lw_addr", bus_addr_o, 32'h0000_0100);
    chk("lw_we", {31'b0, bus_we_o}, 32'd0);
    chk("lw_nodone", {31'b0, acc_done_o}, 32'd0);
    ack_and_check("lw", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // LB 0x103 sign-extends top byte
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    chk("lb_be", {28'b0, bus_be_o}, 32'h8);
    chk("lb_addr", bus_addr_o, 32'h0000_0100);
    ack_and_check("lb", 32'h8012_3456, 32'hFFFF_FF80);

    // LBU 0x103 zero-extends
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
    ack_and_check("lbu", 32'h8012_3456, 32'h0000_0080);

    // SH 0x202
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    chk("sh_we", {31'b0, bus_we_o}, 32'd1);
    chk("sh_be", {28'b0, bus_be_o}, 32'hC);
    chk("sh_wdata", bus_wdata_o, 32'hABCD_ABCD);
    chk("sh_addr", bus_addr_o, 32'h0000_0200);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    chk("sh_done", {31'b0, acc_done_o}, 32'd1);
    tick();

    // LH upper half sign-extends, LHU lower half zero-extends
    issue(1'b0, 3'b001, 32'h0000_0202, 32'h0);
    chk("lh_be", {28'b0, bus_be_o}, 32'hC);
    ack_and_check("lh", 32'h8001_7FFF, 32'hFFFF_8001);
    issue(1'b0, 3'b101, 32'h0000_0100, 32'h0);
    chk("lhu_be", {28'b0, bus_be_o}, 32'h3);
    ack_and_check("lhu", 32'h1234_F00D, 32'h0000_F00D);

    // SB 0x101 replicates byte
    issue(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5);
    chk("sb_be", {28'b0, bus_be_o}, 32'h2);
    chk("sb_wdata", bus_wdata_o, 32'hA5A5_A5A5);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    tick();

    // Reserved funct3 011 behaves as word
    issue(1'b0, 3'b011, 32'h0000_0104, 32'h0);
    chk("rsv_be", {28'b0, bus_be_o}, 32'hF);
    ack_and_check("rsv", 32'h8765_4321, 32'h8765_4321);

    // Misaligned LW 0x101: no bus cycle, error next cycle
    issue(1'b0, 3'b010, 32'h0000_0101, 32'h0);
    chk("mis_req", {31'b0, bus_req_o}, 32'd0);
    chk("mis_flags", {28'b0, acc_done_o, acc_busy_o, acc_misalign_o, acc_bus_err_o}, 32'hE);
    chk("mis_rdata", acc_rdata_o, 32'h0);
    tick();
    chk("mis_idle", {28'b0, acc_done_o, acc_busy_o, acc_misalign_o, acc_bus_err_o}, 32'h0);

    // Timeout (4 cycles): bus_req high exactly 4 cycles then bus error
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    chk("to_req1", {31'b0, bus_req_o}, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("to_reqn", {31'b0, bus_req_o}, 32'd1);
    end
    tick();
    chk("to_req_drop", {31'b0, bus_req_o}, 32'd0);
    chk("to_flags", {28'b0, acc_done_o, acc_busy_o, acc_misalign_o, acc_bus_err_o}, 32'hD);
    chk("to_rdata", acc_rdata_o, 32'h0);
    tick();
    chk("to_idle", {30'b0, acc_done_o, acc_busy_o}, 32'd0);

    // Ack in the last timeout cycle wins
    issue(1'b0, 3'b010, 32'h0000_0304, 32'h0);
    tick(); tick(); tick();
    chk("aw_req4", {31'b0, bus_req_o}, 32'd1);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0BAD_F00D;
    tick();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    chk("aw_flags", {28'b0, acc_done_o, acc_busy_o, acc_misalign_o, acc_bus_err_o}, 32'hC);
    chk("aw_rdata", acc_rdata_o, 32'h0BAD_F00D);
    tick();

    // Reset during a waited bus cycle
    issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    tick();
    chk("rm_req_before", {31'b0, bus_req_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rm_req_async", {31'b0, bus_req_o}, 32'd0);
    chk("rm_busy", {31'b0, acc_busy_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("rm_nodone", {31'b0, acc_done_o}, 32'd0);
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    chk("rm_new_addr", bus_addr_o, 32'h0000_0500);
    ack_and_check("rm_new", 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
